// File: rtl/eightbit_pkg.sv
// Shared definitions for the 8-bit computer: RAM geometry, bus width and
// the program loader state encoding.
package eightbit_pkg;

   localparam int RAM_ADDR_W = 4;
   localparam int RAM_DEPTH  = 16;
   localparam int BUS_W      = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      WRITE,
      SETTLE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/hold_timer.sv
// Loadable 8-bit down-counter that sets the width of each RAM write strobe.
// The counter stops at zero, and the zero flag is asserted while it sits there.
module hold_timer (
   input  logic       fastClk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   output logic       zero
);

   logic [7:0] r_count;

   always_ff @(posedge fastClk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (r_count != 8'd0) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign zero = (r_count == 8'd0);

endmodule

// File: rtl/program_loader.sv
// Streams host bytes into the computer's RAM and zero-fills any tail left
// after a short stream. Each write is held so that it spans a slow-clock edge.
module program_loader
   import eightbit_pkg::*;
#(
   parameter int ADDR_W      = RAM_ADDR_W,
   parameter int DATA_W      = BUS_W,
   parameter int HOLD_CYCLES = 16
) (
   input  logic              fastClk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              prog_mode,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [DATA_W-1:0] prog_data,
   output logic              prog_we,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   loaded
);

   localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   loader_state_t r_state;
   logic          r_lastQ;
   logic          r_fill;
   logic          w_accept;
   logic          w_fillNext;
   logic          w_timerLoad;
   logic          w_timerZero;

   assign w_accept    = (r_state == WAIT) && in_valid && in_ready;
   assign w_fillNext  = (r_state == SETTLE) && (prog_addr != LAST_ADDR) && (r_lastQ || r_fill);
   assign w_timerLoad = w_accept || w_fillNext;

   hold_timer u_holdTimer (
      .fastClk (fastClk),
      .rst     (rst),
      .load    (w_timerLoad),
      .value   (HOLD_LOAD),
      .zero    (w_timerZero)
   );

   // Address and data move only on accept or SETTLE exit, never while prog_we is high.
   always_ff @(posedge fastClk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_lastQ   <= 1'b0;
         r_fill    <= 1'b0;
         in_ready  <= 1'b0;
         prog_mode <= 1'b0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_we   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         loaded    <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= WAIT;
                  prog_mode <= 1'b1;
                  busy      <= 1'b1;
                  in_ready  <= 1'b1;
                  prog_addr <= '0;
                  loaded    <= '0;
                  r_fill    <= 1'b0;
               end
            end
            WAIT: begin
               if (w_accept) begin
                  prog_data <= in_data;
                  r_lastQ   <= in_last;
                  loaded    <= loaded + 1'b1;
                  in_ready  <= 1'b0;
                  prog_we   <= 1'b1;
                  r_state   <= WRITE;
               end
            end
            WRITE: begin
               if (w_timerZero) begin
                  prog_we <= 1'b0;
                  r_state <= SETTLE;
               end
            end
            SETTLE: begin
               if (prog_addr == LAST_ADDR) begin
                  r_state   <= DONE;
                  done      <= 1'b1;
                  prog_mode <= 1'b0;
               end else if (r_lastQ || r_fill) begin
                  prog_addr <= prog_addr + 1'b1;
                  r_fill    <= 1'b1;
                  prog_data <= '0;
                  prog_we   <= 1'b1;
                  r_state   <= WRITE;
               end else begin
                  prog_addr <= prog_addr + 1'b1;
                  in_ready  <= 1'b1;
                  r_state   <= WAIT;
               end
            end
            DONE: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side RAM programmer for the 8-bit computer. Accepts a byte stream over a valid/ready handshake, holds the computer in program mode, and writes each byte into consecutive RAM addresses starting at 0. Each write is held long enough to span an edge of the computer's divided clock. If the stream ends early, the rest of RAM is zero-filled, then the computer is released to run. The block sits between the host input pins and the computer's `prog_mode`/`addr`/data-bus programming path.

## Interface
- `ADDR_W`, 4: RAM address width; depth is 2^ADDR_W = 16.
- `DATA_W`, 8: RAM word / stream byte width.
- `HOLD_CYCLES`, 16: `fastClk` cycles each write is held. Must be ≥ one slow-clock period plus 1. Legal range is 1..255.

- `fastClk`  in  1  sole clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_valid`  in  1  stream byte present.
- `in_data`  in  DATA_W  stream byte.
- `in_last`  in  1  qualifies the final byte of the stream; meaningful only with `in_valid`.
- `in_ready`  out  1  loader can accept a byte.
- `prog_mode`  out  1  high while loading; drives the computer's program-mode input.
- `prog_addr`  out  ADDR_W  RAM address being written.
- `prog_data`  out  DATA_W  RAM write data.
- `prog_we`  out  1  write strobe, held for HOLD_CYCLES.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `loaded`  out  ADDR_W+1  count of stream bytes accepted in the current or last load; excludes zero-fill writes.

## Operation
- All outputs are registered.
- Reset values: `in_ready`=0, `prog_mode`=0, `prog_addr`=0, `prog_data`=0, `prog_we`=0, `busy`=0, `done`=0, `loaded`=0, state=IDLE.
- **IDLE**
  - `start`=1 → WAIT.
  - Entering WAIT sets `prog_mode`=1, `prog_addr`=0, `loaded`=0 and clears the fill flag.
- **WAIT**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `in_data` to `prog_data` and `in_last` to `last_q`, increment `loaded`, load the hold timer with HOLD_CYCLES-1 → WRITE. `in_ready` drops in the same transition.
- **WRITE**
  - `prog_we`=1; address and data are stable.
  - When the timer reaches 0 → SETTLE.
- **SETTLE**
  - Lasts 1 cycle, with `prog_we`=0 and address/data unchanged.
  - Exit depends on `prog_addr` and the flags:
    - `prog_addr`=2^ADDR_W-1 → DONE.
    - Else if `last_q` or fill flag: increment `prog_addr`, set the fill flag, set `prog_data`=0, reload the timer → WRITE (zero-fill).
    - Else: increment `prog_addr` → WAIT.
- **DONE**
  - Lasts 1 cycle, with `done`=1 and `prog_mode`=0, then → IDLE.
  - `loaded` holds its value until the next `start`.
- Boundary conditions:
  - `start` while not in IDLE is ignored.
  - `in_last` on the byte at address 15 causes no zero-fill.
  - A 16th byte without `in_last` completes normally; the stream's next byte is not accepted.
  - `prog_addr` never wraps; its maximum is 15.
  - `in_valid` outside WAIT is not consumed.
  - Asserting `rst` mid-write drops `prog_we` and `prog_mode` immediately (asynchronously). The partially written RAM content is unspecified.

## Timing
- `start` sampled at edge n → `prog_mode`=1, `busy`=1, `in_ready`=1 from n+1.
- Byte accepted at edge k → `prog_we`=1 from k+1 through k+HOLD_CYCLES, SETTLE at k+HOLD_CYCLES+1, next `in_ready`=1 from k+HOLD_CYCLES+2.
- Per byte, the minimum is HOLD_CYCLES+2 cycles.
- Per zero-fill word, the cost is HOLD_CYCLES+1 cycles.
- Final SETTLE at edge m → `done`=1 and `prog_mode`=0 during m+1; `busy`=0 from m+2.
- `prog_addr`/`prog_data` change only on WAIT→WRITE (data) and SETTLE exit (address, fill data). They never change while `prog_we`=1.

## Structure
- Shared package `eightbit_pkg` holds:
  - the `loader_state_t` enum {IDLE, WAIT, WRITE, SETTLE, DONE};
  - the constants `RAM_ADDR_W`=4, `RAM_DEPTH`=16 and `BUS_W`=8. These are shared with the RAM and top level.
- One sub-module, `hold_timer`, is a loadable 8-bit down-counter with ports `load`, `value`, and a `zero` flag.

## Test plan
- HOLD_CYCLES=4, stream of 16 bytes 0x10..0x1F, none with `in_last` until the byte at address 15 → 16 `prog_we` pulses each 4 cycles wide, address i gets data 0x10+i, `loaded`=16, one `done` pulse, no zero-fill.
- Stream of 3 bytes 0xA1, 0xB2, 0xC3 with `in_last` on 0xC3 → addresses 0..2 get those bytes and addresses 3..15 get 0x00, `loaded`=3, `done` follows the address-15 SETTLE.
- `in_valid` toggled randomly, including during WRITE/SETTLE → bytes are accepted only when `in_ready`=1, none are dropped or duplicated, and `prog_data` is stable whenever `prog_we`=1.
- `start` re-pulsed mid-load at address 5 → ignored; the load continues and `prog_addr` does not reset.
- `rst` asserted during WRITE at address 7 → all outputs are at their reset values asynchronously. A new `start` then restarts at address 0 with `loaded`=0.
- Single byte 0xEE with `in_last`, HOLD_CYCLES=1 → 1-cycle `prog_we` at address 0, 15 zero-fill writes, `done` exactly once, and `loaded`=1.
